ar_req_fifo: RTL
================

# ar_req_fifo

Parametrised AXI read-address (AR) request queue between the cache's AXI slave port and the cache read controller. Accepts AR beats with a valid/ready handshake, buffers up to DEPTH requests in order, and presents each request at the head with precomputed burst byte count and an AXI-legality flag. Provides occupancy, almost-full and synchronous flush. An optional empty-queue bypass path can be compiled in.

## Interface
- ADDR_WIDTH, 64, AR address width
- ID_WIDTH, 4, AR ID width
- DEPTH, 8, entry count; power of two, at least 2
- AFULL_THRESH, DEPTH-2, count at or above which almost_full asserts; range 1..DEPTH

- clk  in  1  single clock; all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous queue clear
- s_arvalid  in  1  AR request valid
- s_arready  out  1  queue can accept
- s_araddr  in  ADDR_WIDTH  request address
- s_arid  in  ID_WIDTH  request ID
- s_arburst  in  2  burst type
- s_arsize  in  3  log2 bytes per beat
- s_arlen  in  8  beats minus one
- m_valid  out  1  head request valid
- m_ready  in  1  controller takes head
- m_addr, m_id, m_burst, m_size, m_len  out  matching widths  head request fields
- m_bytes  out  16  total burst bytes, (len+1) << size
- m_illegal  out  1  head request violates AXI rules
- count  out  $clog2(DEPTH)+1  current occupancy
- almost_full  out  1  count >= AFULL_THRESH

## Operation
- Push: s_arvalid && s_arready. Pop: m_valid && m_ready. Strict FIFO order; no reordering by ID.
- s_arready = !full && !flush. m_valid = !empty && !flush, plus the bypass term below.
- m_* payload outputs are driven to 0 whenever m_valid = 0.
- Read and write pointers are $clog2(DEPTH)+1 bits wide and wrap naturally. Full is indicated when the pointer MSBs differ and the remaining bits are equal.
- Legality is evaluated at push and stored with the entry. m_illegal = 1 if any of the following holds:
  - burst == 2'b11 (reserved)
  - burst is WRAP and len is not one of 1, 3, 7, 15
  - burst is WRAP and the address is not aligned to 1<<size
  - burst is INCR and {1'b0, addr[11:0]} + m_bytes > 13'h1000 (4 KB crossing)
- FIXED bursts are never flagged.
- Illegal requests are still queued and popped normally. Response handling is downstream.
- m_bytes is computed with 16-bit arithmetic. The maximum value is 256 << 7 = 32768, so it never overflows.
- Simultaneous push and pop with the queue neither empty nor full: count is unchanged and both pointers advance.
- When full, no push can occur, even if a pop happens in the same cycle.
- Flush has priority over push and pop. It holds s_arready and m_valid low in its cycle, and in the next cycle pointers = 0 and count = 0.

## Timing
- Reset values: s_arready = 1, m_valid = 0, count = 0, almost_full = 0, all m_* = 0, pointers = 0.
- Without bypass: push at cycle N gives m_valid at N+1, when that entry is the head.
- s_arready, count and almost_full are functions of registered state only. They have no combinational path from s_arvalid or m_ready.
- count and almost_full update on the edge following the push or pop.
- Reset asserted mid-burst or mid-handshake clears state immediately (asynchronously). Any in-flight request is lost. After release, the first push is possible in the first cycle.

## Configuration
- Macro name: AR_REQ_FIFO_BYPASS_EN.
- Defined:
  - When empty and flush = 0, m_valid = s_arvalid and the m_* fields come combinationally from s_* and the legality checker.
  - If m_ready = 1 in that cycle, the request passes through without being stored. count stays 0 and the pointers do not move.
  - If m_ready = 0, the request is stored as a normal push.
  - Latency is 0 cycles when empty.
- Undefined: no combinational path from s_* to m_*. Minimum latency is 1 cycle.

## Structure
- Package ar_fifo_pkg:
  - BURST_FIXED = 2'd0, BURST_INCR = 2'd1, BURST_WRAP = 2'd2
  - packed struct ar_entry_t {addr, id, burst, size, len, illegal}, parameterised via package localparams matching defaults
  - function burst_bytes(len, size)
- Sub-module ar_legality_chk: a combinational checker that takes addr[11:0], burst, size, len and outputs illegal and bytes. It is shared by the push path and the bypass path.
- Storage: a register array of ar_entry_t. No reset on the array; only pointers, count and flags are reset.

## Test plan
- Reset, then push 8 INCR requests (addr 0x1000 + 0x40*i, len 3, size 3, id i) with m_ready = 0:
  - s_arready drops after the 8th push
  - count = 8 and almost_full = 1 from count 6
  - draining returns ids 0..7 in order, each with m_bytes = 32
- Full queue with s_arvalid = 1 and m_ready = 1 in the same cycle: the pop occurs and no push occurs; the next cycle accepts the push, and count returns to 8.
- Legality checks:
  - WRAP, len 5 → m_illegal = 1
  - WRAP, addr 0x104, size 3 → m_illegal = 1
  - INCR, addr 0xFF0, len 3, size 3 (32 bytes, crosses 4 KB) → m_illegal = 1
  - burst 2'b11 → m_illegal = 1
  - FIXED, addr 0xFFF, len 255 → m_illegal = 0
- Maximum burst: len 255, size 7 → m_bytes = 32768.
- Flush with 5 entries and s_arvalid = 1 asserted: no handshake occurs in the flush cycle; the next cycle has count = 0 and m_valid = 0, and pointer wrap is correct over a following 20-request stream.
- Assert rst_n low mid-stream with 3 entries: all outputs reach reset values asynchronously. With AR_REQ_FIFO_BYPASS_EN, an empty queue with m_ready = 1 shows m_valid in the same cycle as s_arvalid, and count stays 0.

Source files
------------

// File: rtl/ar_fifo_pkg.sv
// ar_fifo_pkg: shared types, burst encodings and the burst byte-count helper
// for the AXI read-address request queue.
package ar_fifo_pkg;

  // Default field widths; the stored entry is sized with these.
  localparam int AR_ADDR_W = 64;
  localparam int AR_ID_W   = 4;

  // AXI burst type encodings.
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_RSVD  = 2'd3;

  // One queued AR request. The legality flag is evaluated once at push and
  // travels with the entry so the head path needs no second checker.
  typedef struct packed {
    logic [AR_ADDR_W-1:0] addr;
    logic [AR_ID_W-1:0]   id;
    logic [1:0]           burst;
    logic [2:0]           size;
    logic [7:0]           len;
    logic                 illegal;
  } ar_entry_t;

  // Total burst bytes = (len + 1) << size. Largest value is 256 << 7 = 32768,
  // so 16 bits never overflow.
  function automatic logic [15:0] burst_bytes(input logic [7:0] len,
                                               input logic [2:0] size);
    return ({8'd0, len} + 16'd1) << size;
  endfunction

endpackage

// File: rtl/ar_legality_chk.sv
// ar_legality_chk: combinational AXI AR legality checker. Given the low 12
// address bits, burst type, size and length it flags reserved bursts, bad
// WRAP lengths, misaligned WRAP addresses and INCR bursts that cross a 4 KB
// boundary, and reports the total burst byte count.
module ar_legality_chk
  import ar_fifo_pkg::*;
(
  input  logic [11:0] addr_lo,
  input  logic [1:0]  burst,
  input  logic [2:0]  size,
  input  logic [7:0]  len,
  output logic        illegal,
  output logic [15:0] bytes
);

  logic [11:0] align_mask;
  logic [16:0] end_off;
  logic        wrap_len_ok;
  logic        misaligned;
  logic        crosses_4k;

  // Evaluate every rule in parallel, then select by burst type.
  always_comb begin
    bytes       = burst_bytes(len, size);
    // Ones in the bits below 1<<size; size is at most 7 so this fits 12 bits.
    align_mask  = ~(12'hFFF << size);
    misaligned  = |(addr_lo & align_mask);
    // Wide enough for 0xFFF + 32768 so the comparison never wraps.
    end_off     = {5'd0, addr_lo} + {1'b0, bytes};
    crosses_4k  = end_off > 17'h0_1000;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    illegal     = 1'b0;
    case (burst)
      BURST_FIXED: illegal = 1'b0;
      BURST_INCR:  illegal = crosses_4k;
      BURST_WRAP:  illegal = !wrap_len_ok || misaligned;
      default:     illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ar_req_fifo.sv
// ar_req_fifo: in-order AXI AR request queue with precomputed burst bytes and
// legality flag at the head, occupancy count, almost-full and synchronous
// flush. Defining AR_REQ_FIFO_BYPASS_EN adds a zero-latency path from the
// slave inputs to the head outputs while the queue is empty.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. s_arready depends only on registered state and flush; m_valid
// never depends on m_ready. Payload is held stable by the source while valid
// is high and not yet accepted; the m_* payload reads as zero when m_valid=0.
module ar_req_fifo
  import ar_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = AR_ADDR_W,  // at least 12, at most AR_ADDR_W
  parameter int ID_WIDTH     = AR_ID_W,    // at most AR_ID_W
  parameter int DEPTH        = 8,          // power of two, at least 2
  parameter int AFULL_THRESH = DEPTH - 2   // 1..DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic [ID_WIDTH-1:0]     s_arid,
  input  logic [1:0]              s_arburst,
  input  logic [2:0]              s_arsize,
  input  logic [7:0]              s_arlen,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [ID_WIDTH-1:0]     m_id,
  output logic [1:0]              m_burst,
  output logic [2:0]              m_size,
  output logic [7:0]              m_len,
  output logic [15:0]             m_bytes,
  output logic                    m_illegal,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    almost_full
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] AFULL_CNT = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] count_q, count_nxt;
  logic          almost_full_q;
  logic          full, empty;
  logic          push_hs, do_push, do_pop;

  ar_entry_t     mem [DEPTH];
  ar_entry_t     new_entry;
  ar_entry_t     head;

  logic          chk_illegal;
  logic [15:0]   chk_bytes;

`ifdef AR_REQ_FIFO_BYPASS_EN
  logic          bypass_sel;
  logic          pass_thru;
`else
  // Byte count at the input is only needed by the bypass path.
  logic          unused_chk_bytes;
  assign unused_chk_bytes = ^chk_bytes;
`endif

  // One checker serves the push path (and the bypass path when built in).
  ar_legality_chk u_chk (
    .addr_lo (s_araddr[11:0]),
    .burst   (s_arburst),
    .size    (s_arsize),
    .len     (s_arlen),
    .illegal (chk_illegal),
    .bytes   (chk_bytes)
  );

  // Queue status, handshakes and the entry to be written.
  always_comb begin
    full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
    empty = (wr_ptr == rd_ptr);

    s_arready = !full && !flush;
    push_hs   = s_arvalid && s_arready;

`ifdef AR_REQ_FIFO_BYPASS_EN
    bypass_sel = empty && !flush;
    m_valid    = (!empty && !flush) || (bypass_sel && s_arvalid);
    // Taken straight through: nothing is stored and nothing is popped.
    pass_thru  = bypass_sel && s_arvalid && m_ready;
    do_push    = push_hs && !pass_thru;
    do_pop     = m_valid && m_ready && !empty;
`else
    m_valid    = !empty && !flush;
    do_push    = push_hs;
    do_pop     = m_valid && m_ready;
`endif

    new_entry         = '0;
    new_entry.addr    = AR_ADDR_W'(s_araddr);
    new_entry.id      = AR_ID_W'(s_arid);
    new_entry.burst   = s_arburst;
    new_entry.size    = s_arsize;
    new_entry.len     = s_arlen;
    new_entry.illegal = chk_illegal;

    count_nxt = count_q;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count_q + PTR_ONE;
      2'b01:   count_nxt = count_q - PTR_ONE;
      default: count_nxt = count_q;
    endcase
  end

  // Pointer, occupancy and almost-full registers; flush clears them next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_q       <= '0;
      almost_full_q <= 1'b0;
    end else if (flush) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count_q       <= count_nxt;
      almost_full_q <= (count_nxt >= AFULL_CNT);
    end
  end

  // Entry storage; no reset, validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[IW-1:0]] <= new_entry;
  end

  // Head presentation: stored head, or the live input when bypassing.
  always_comb begin
    head      = mem[rd_ptr[IW-1:0]];
    m_addr    = '0;
    m_id      = '0;
    m_burst   = '0;
    m_size    = '0;
    m_len     = '0;
    m_bytes   = '0;
    m_illegal = 1'b0;
    if (m_valid) begin
`ifdef AR_REQ_FIFO_BYPASS_EN
      if (empty) begin
        m_addr    = s_araddr;
        m_id      = s_arid;
        m_burst   = s_arburst;
        m_size    = s_arsize;
        m_len     = s_arlen;
        m_bytes   = chk_bytes;
        m_illegal = chk_illegal;
      end else begin
`else
      begin
`endif
        m_addr    = ADDR_WIDTH'(head.addr);
        m_id      = ID_WIDTH'(head.id);
        m_burst   = head.burst;
        m_size    = head.size;
        m_len     = head.len;
        m_bytes   = burst_bytes(head.len, head.size);
        m_illegal = head.illegal;
      end
    end
  end

  assign count       = count_q;
  assign almost_full = almost_full_q;

endmodule
